// File: rtl/trisc_sequencer_if.sv
// Control bundle between the TRISC sequencer and the datapath/RAM stage.
// The master side is the sequencer. The slave side is the datapath.
interface trisc_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       acc_zero;
  logic       pc_inc;
  logic       pc_load;
  logic       addr_sel;
  logic       ram_en;
  logic       ram_we;
  logic       ir_load;
  logic       acc_load_mem;
  logic       buf_load;
  logic       acc_load_alu;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  run, opcode, acc_zero,
    output pc_inc, pc_load, addr_sel, ram_en, ram_we, ir_load,
           acc_load_mem, buf_load, acc_load_alu, halted, state
  );

  modport slave (
    output run, opcode, acc_zero,
    input  pc_inc, pc_load, addr_sel, ram_en, ram_we, ir_load,
           acc_load_mem, buf_load, acc_load_alu, halted, state
  );
endinterface

// File: rtl/trisc_sequencer.sv
// Fetch/decode/execute control FSM for the 4-bit TRISC accumulator CPU.
// Its outputs are Moore outputs. They depend only on the state, the latched opcode and the latched zero flag.
module trisc_sequencer (
  input  logic             clock,
  input  logic             reset,
  trisc_sequencer_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] F1   = 3'd1;
  localparam logic [2:0] F2   = 3'd2;
  localparam logic [2:0] DEC  = 3'd3;
  localparam logic [2:0] E1   = 3'd4;
  localparam logic [2:0] E2   = 3'd5;
  localparam logic [2:0] HALT = 3'd6;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  logic [2:0] stateQ, stateD;
  logic [3:0] opQ;
  logic       condQ;

  logic pcInc, pcLoad, addrSel, ramEn, ramWe, irLoad;
  logic accLoadMem, bufLoad, accLoadAlu, haltedO;

  // "Done" target: the run switch is sampled only at instruction boundaries.
  logic [2:0] doneState;
  assign doneState = bus.run ? F1 : IDLE;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: stateD = bus.run ? F1 : IDLE;
      F1:   stateD = F2;
      F2:   stateD = DEC;
      DEC: begin
        // Branch on the live opcode because opQ is only loaded at the end of DEC.
        case (bus.opcode)
          OP_LDA, OP_STA, OP_ADD, OP_JMP, OP_JZ, OP_LDI: stateD = E1;
          OP_HLT:                                        stateD = HALT;
          default:                                       stateD = doneState;
        endcase
      end
      E1:   stateD = (opQ == OP_LDA || opQ == OP_ADD) ? E2 : doneState;
      E2:   stateD = doneState;
      HALT: stateD = HALT;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= IDLE;
      opQ    <= OP_NOP;
      condQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (stateQ == DEC) begin
        opQ   <= bus.opcode;
        condQ <= bus.acc_zero;
      end
    end
  end

  always_comb begin
    pcInc      = 1'b0;
    pcLoad     = 1'b0;
    addrSel    = 1'b0;
    ramEn      = 1'b0;
    ramWe      = 1'b0;
    irLoad     = 1'b0;
    accLoadMem = 1'b0;
    bufLoad    = 1'b0;
    accLoadAlu = 1'b0;
    haltedO    = 1'b0;
    case (stateQ)
      F1: begin
        addrSel = 1'b1;
        ramEn   = 1'b1;
      end
      F2: begin
        irLoad = 1'b1;
        pcInc  = 1'b1;
      end
      E1: begin
        case (opQ)
          OP_LDA: ramEn = 1'b1;
          OP_STA: begin
            ramEn = 1'b1;
            ramWe = 1'b1;
          end
          OP_ADD: begin
            ramEn   = 1'b1;
            bufLoad = 1'b1;
          end
          OP_JMP: pcLoad     = 1'b1;
          OP_JZ:  pcLoad     = condQ;
          OP_LDI: accLoadMem = 1'b1;
          default: ;
        endcase
      end
      E2: begin
        accLoadMem = (opQ == OP_LDA);
        accLoadAlu = (opQ == OP_ADD);
      end
      HALT: haltedO = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_inc       = pcInc;
  assign bus.pc_load      = pcLoad;
  assign bus.addr_sel     = addrSel;
  assign bus.ram_en       = ramEn;
  assign bus.ram_we       = ramWe;
  assign bus.ir_load      = irLoad;
  assign bus.acc_load_mem = accLoadMem;
  assign bus.buf_load     = bufLoad;
  assign bus.acc_load_alu = accLoadAlu;
  assign bus.halted       = haltedO;
  assign bus.state        = stateQ;

endmodule

// File: tb/tb_trisc_sequencer.sv
// Directed bench for trisc_sequencer. Each step checks the state code and all strobes against hand-derived vectors.
module tb_trisc_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  trisc_sequencer_if busIf ();

  trisc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf.master)
  );

  always #5 clock = ~clock;

  // Strobe bit positions: halted, pc_inc, pc_load, addr_sel, ram_en, ram_we, ir_load, acc_load_mem, buf_load, acc_load_alu
  localparam logic [9:0] NONE   = 10'b0000000000;
  localparam logic [9:0] HLTD   = 10'b1000000000;
  localparam logic [9:0] PCINC  = 10'b0100000000;
  localparam logic [9:0] PCLD   = 10'b0010000000;
  localparam logic [9:0] ASEL   = 10'b0001000000;
  localparam logic [9:0] RAMEN  = 10'b0000100000;
  localparam logic [9:0] RAMWE  = 10'b0000010000;
  localparam logic [9:0] IRLD   = 10'b0000001000;
  localparam logic [9:0] ACCMEM = 10'b0000000100;
  localparam logic [9:0] BUFLD  = 10'b0000000010;
  localparam logic [9:0] ACCALU = 10'b0000000001;

  function automatic logic [12:0] observe();
    return {busIf.state, busIf.halted, busIf.pc_inc, busIf.pc_load, busIf.addr_sel,
            busIf.ram_en, busIf.ram_we, busIf.ir_load, busIf.acc_load_mem,
            busIf.buf_load, busIf.acc_load_alu};
  endfunction

  task automatic chk(input string tag, input logic [2:0] st, input logic [9:0] strobes);
    logic [12:0] obs;
    logic [12:0] expv;
    obs  = observe();
    expv = {st, strobes};
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s: observed state=%0d strobes=%b, expected state=%0d strobes=%b",
               tag, obs[12:10], obs[9:0], expv[12:10], expv[9:0]);
      end
  endtask

  // Advance one clock; inputs changed after this are applied before the next rising edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    busIf.run = 1'b0;
    busIf.opcode = 4'h0;
    busIf.acc_zero = 1'b0;
    cyc();
    cyc();
    chk("reset", 3'd0, NONE);

    reset = 1'b0;
    busIf.run = 1'b1;
    cyc(); chk("start_f1", 3'd1, ASEL | RAMEN);
    busIf.opcode = 4'h1;
    cyc(); chk("lda_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("lda_dec", 3'd3, NONE);
    cyc(); chk("lda_e1", 3'd4, RAMEN);
    cyc(); chk("lda_e2", 3'd5, ACCMEM);
    cyc(); chk("lda_f1", 3'd1, ASEL | RAMEN);

    // JZ with the zero flag taken. The flag drops during E1 and must be ignored.
    busIf.opcode = 4'h5;
    busIf.acc_zero = 1'b1;
    cyc(); chk("jz1_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("jz1_dec", 3'd3, NONE);
    @(posedge clock);
    #1 busIf.acc_zero = 1'b0;
    @(negedge clock);
    chk("jz1_e1", 3'd4, PCLD);
    cyc(); chk("jz1_f1", 3'd1, ASEL | RAMEN);

    cyc(); chk("jz0_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("jz0_dec", 3'd3, NONE);
    cyc(); chk("jz0_e1", 3'd4, NONE);
    cyc(); chk("jz0_f1", 3'd1, ASEL | RAMEN);

    busIf.opcode = 4'h2;
    cyc(); chk("sta_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("sta_dec", 3'd3, NONE);
    cyc(); chk("sta_e1", 3'd4, RAMEN | RAMWE);
    cyc(); chk("sta_f1", 3'd1, ASEL | RAMEN);

    busIf.opcode = 4'hC;
    cyc(); chk("undef_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("undef_dec", 3'd3, NONE);
    cyc(); chk("undef_f1", 3'd1, ASEL | RAMEN);

    busIf.opcode = 4'h4;
    cyc(); chk("jmp_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("jmp_dec", 3'd3, NONE);
    cyc(); chk("jmp_e1", 3'd4, PCLD);
    cyc(); chk("jmp_f1", 3'd1, ASEL | RAMEN);

    busIf.opcode = 4'h6;
    cyc(); chk("ldi_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("ldi_dec", 3'd3, NONE);
    cyc(); chk("ldi_e1", 3'd4, ACCMEM);
    cyc(); chk("ldi_f1", 3'd1, ASEL | RAMEN);

    // ADD with run released in E1: the instruction completes, then the FSM parks in IDLE.
    busIf.opcode = 4'h3;
    cyc(); chk("add_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("add_dec", 3'd3, NONE);
    cyc(); chk("add_e1", 3'd4, RAMEN | BUFLD);
    busIf.run = 1'b0;
    cyc(); chk("add_e2", 3'd5, ACCALU);
    cyc(); chk("add_idle", 3'd0, NONE);
    cyc(); chk("idle_hold", 3'd0, NONE);

    // STA aborted by reset in E1.
    busIf.run = 1'b1;
    busIf.opcode = 4'h2;
    cyc(); chk("sta2_f1", 3'd1, ASEL | RAMEN);
    cyc(); chk("sta2_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("sta2_dec", 3'd3, NONE);
    cyc(); chk("sta2_e1", 3'd4, RAMEN | RAMWE);
    reset = 1'b1;
    cyc(); chk("sta2_reset", 3'd0, NONE);
    reset = 1'b0;

    busIf.opcode = 4'h7;
    cyc(); chk("hlt_f1", 3'd1, ASEL | RAMEN);
    cyc(); chk("hlt_f2", 3'd2, IRLD | PCINC);
    cyc(); chk("hlt_dec", 3'd3, NONE);
    cyc(); chk("hlt_halt", 3'd6, HLTD);
    busIf.run = 1'b0;
    cyc(); chk("hlt_run0", 3'd6, HLTD);
    busIf.run = 1'b1;
    cyc(); chk("hlt_run1", 3'd6, HLTD);
    reset = 1'b1;
    cyc(); chk("hlt_reset", 3'd0, NONE);
    reset = 1'b0;
    busIf.run = 1'b0;
    cyc(); chk("post_reset_idle", 3'd0, NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
